// File: rtl/au_op_sequencer.sv
// rtl/au_op_sequencer.sv - registered handshake front/back end for the 4-bit AU
// Drives AU operands from registers, waits for the AU to settle, then captures {Cout,D}.
module au_op_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [2:0]       in_mode,
  input  logic             in_acc,
  output logic [3:0]       au_a,
  output logic [3:0]       au_b,
  output logic [1:0]       au_s,
  output logic             au_cin,
  input  logic [3:0]       au_d,
  input  logic             au_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [4:0]       res_data,
  output logic             res_zero,
  output logic [3:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic [3:0]       au_a_q;
  logic [3:0]       au_b_q;
  logic [1:0]       au_s_q;
  logic             au_cin_q;
  logic [4:0]       res_data_q;
  logic             res_zero_q;
  logic [3:0]       acc_q;
  logic [CNT_W-1:0] op_count_q;

  logic [3:0]       au_a_d;
  logic [CNT_W-1:0] op_count_d;

  // Accumulate mode feeds the previous AU result back in as operand A.
  assign au_a_d     = in_acc ? acc_q : in_a;
  assign op_count_d = op_count_q + CNT_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      au_a_q      <= 4'd0;
      au_b_q      <= 4'd0;
      au_s_q      <= 2'd0;
      au_cin_q    <= 1'b0;
      res_data_q  <= 5'd0;
      res_zero_q  <= 1'b1;
      acc_q       <= 4'd0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            au_a_q              <= au_a_d;
            au_b_q              <= in_b;
            {au_s_q, au_cin_q}  <= in_mode;
            cnt_q               <= CNT_INIT;
            in_ready_q          <= 1'b0;
            state_q             <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            res_data_q  <= {au_cout, au_d};
            res_zero_q  <= (au_d == 4'd0);
            acc_q       <= au_d;
            op_count_q  <= op_count_d;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign au_a      = au_a_q;
  assign au_b      = au_b_q;
  assign au_s      = au_s_q;
  assign au_cin    = au_cin_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_au_op_sequencer.sv
// tb/tb_au_op_sequencer.sv - scoreboard bench for au_op_sequencer with a behavioural AU
module tb_au_op_sequencer;

  localparam int SETTLE = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic [2:0] in_mode = 3'd0;
  logic       in_acc = 1'b0;
  logic [3:0] au_a, au_b;
  logic [1:0] au_s;
  logic       au_cin;
  logic [3:0] au_d;
  logic       au_cout;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [4:0] res_data;
  logic       res_zero;
  logic [3:0] acc;
  logic [7:0] op_count;

  au_op_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_acc(in_acc),
    .au_a(au_a), .au_b(au_b), .au_s(au_s), .au_cin(au_cin),
    .au_d(au_d), .au_cout(au_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero),
    .acc(acc), .op_count(op_count)
  );

  always #10 CLK = ~CLK;

  // AU: 4:1 B-select mux followed by a 4-bit adder with carry in.
  logic [3:0] bsel;
  always_comb begin
    bsel = 4'd0;
    case (au_s)
      2'b00:   bsel = au_b;
      2'b01:   bsel = ~au_b;
      2'b10:   bsel = 4'd0;
      default: bsel = 4'hF;
    endcase
    {au_cout, au_d} = 5'(au_a) + 5'(bsel) + 5'(au_cin);
  end

  typedef struct {
    logic [4:0] data;
    logic       zero;
    logic [3:0] accv;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] m_acc = 4'd0;
  logic [7:0] m_cnt = 8'd0;
  logic       rv_prev = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_res(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] m);
    int r;
    case (m)
      3'd0:    r = int'(a) + int'(b);
      3'd1:    r = int'(a) + int'(b) + 1;
      3'd2:    r = int'(a) + (15 - int'(b));
      3'd3:    r = int'(a) + (15 - int'(b)) + 1;
      3'd4:    r = int'(a);
      3'd5:    r = int'(a) + 1;
      3'd6:    r = int'(a) + 15;
      default: r = 16 + int'(a);
    endcase
    return 5'(r);
  endfunction

  always @(negedge CLK) begin
    if (!RST && res_valid && !rv_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_zero", 32'(res_zero), 32'(e.zero));
        check("acc", 32'(acc), 32'(e.accv));
        check("op_count", 32'(op_count), 32'(e.cnt));
        check("latency", 32'(cyc - e.cyc), 32'(SETTLE));
      end
    end
    rv_prev = res_valid;
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) check("timeout_in_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_rv();
    int n = 0;
    while (!res_valid && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!res_valid) check("timeout_res_valid", 32'd0, 32'd1);
  endtask

  // Called at a negedge with in_ready=1 and the request already driven.
  task automatic accept();
    exp_t       e;
    logic [3:0] opa;
    opa    = in_acc ? m_acc : in_a;
    e.data = exp_res(opa, in_b, in_mode);
    e.zero = (e.data[3:0] == 4'd0);
    e.accv = e.data[3:0];
    m_acc  = e.data[3:0];
    m_cnt  = m_cnt + 8'd1;
    e.cnt  = m_cnt;
    @(posedge CLK);
    @(negedge CLK);
    e.cyc = cyc;
    sb_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] m,
                       input logic accf);
    wait_ready();
    in_a = a; in_b = b; in_mode = m; in_acc = accf; in_valid = 1'b1;
    accept();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    sb_q.delete();
    m_acc = 4'd0;
    m_cnt = 8'd0;
  endtask

  initial begin
    #25;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_au", 32'({au_a, au_b, au_s, au_cin}), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_zero", 32'(res_zero), 32'd1);
    check("rst_acc_cnt", 32'({acc, op_count}), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Basic add, single-cycle result with res_ready held high.
    do_op(4'd5, 4'd3, 3'b000, 1'b0);
    wait_rv();
    @(negedge CLK);
    check("res_valid_one_cycle", 32'(res_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);

    do_op(4'd5, 4'd3, 3'b011, 1'b0);
    do_op(4'd3, 4'd5, 3'b011, 1'b0);
    do_op(4'd0, 4'd0, 3'b110, 1'b0);
    do_op(4'd1, 4'd0, 3'b110, 1'b0);
    do_op(4'd9, 4'd6, 3'b111, 1'b0);
    do_op(4'd7, 4'd2, 3'b010, 1'b0);
    drain();

    // Accumulate from reset; in_a must be ignored.
    do_reset();
    repeat (3) do_op(4'hF, 4'd0, 3'b101, 1'b1);
    drain();
    check("acc_after_3", 32'(acc), 32'd3);
    check("op_count_after_3", 32'(op_count), 32'd3);

    // Backpressure: new request presented while the result is held.
    res_ready = 1'b0;
    do_op(4'd9, 4'd2, 3'b000, 1'b0);
    wait_rv();
    in_a = 4'd4; in_b = 4'd4; in_mode = 3'b001; in_acc = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_data", 32'(res_data), 32'd11);
      check("bp_au", 32'({au_a, au_b, au_s, au_cin}), 32'({4'd9, 4'd2, 2'b00, 1'b0}));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_res_valid", 32'(res_valid), 32'd0);
    accept();
    drain();

    // Asynchronous reset in the middle of SETTLE.
    do_op(4'd7, 4'd7, 3'b000, 1'b0);
    #2 RST = 1'b1;
    #1;
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_au", 32'({au_a, au_b, au_s, au_cin}), 32'd0);
    check("arst_acc_cnt", 32'({acc, op_count}), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    m_acc = 4'd0;
    m_cnt = 8'd0;
    repeat (3) @(negedge CLK);
    check("arst_no_capture", 32'({res_valid, op_count}), 32'd0);

    // First acceptance at the first edge after release, then wrap op_count.
    in_a = 4'd2; in_b = 4'd1; in_mode = 3'b000; in_acc = 1'b0; in_valid = 1'b1;
    RST = 1'b0;
    accept();
    for (int i = 0; i < 255; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    drain();
    check("op_count_wrap", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/au_op_sequencer.md
Name: au_op_sequencer

Overview:
- Registered front/back end for the 4-bit arithmetic unit (AU or AU2: 4:1 mux B-select followed by a ripple or CLA adder).
- Upstream, it accepts one operation per valid/ready handshake and drives the AU operand and select lines from registers.
- It then waits a fixed number of clock cycles so the gate-delayed AU logic can settle.
- Downstream, it captures {Cout,D} into a result register with flags, an accumulator and an operation counter, and presents the result on a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 2, clock cycles between driving the AU and sampling its outputs. Legal range 1..15. The default of 2 is sized for a 200ns CLK period.
- CNT_W, 8, width of the op_count counter.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- in_a  input  4  operand A; ignored when in_acc=1.
- in_b  input  4  operand B.
- in_mode  input  3  {S[1:0],Cin}, same encoding as the AU.
- in_acc  input  1  1 = use the acc register as operand A.
- au_a  output  4  registered A to the AU.
- au_b  output  4  registered B to the AU.
- au_s  output  2  registered S to the AU.
- au_cin  output  1  registered Cin to the AU.
- au_d  input  4  AU sum output D.
- au_cout  input  1  AU carry output.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_data  output  5  captured {au_cout,au_d}.
- res_zero  output  1  res_data[3:0]==0.
- acc  output  4  accumulator, updated with au_d on every capture.
- op_count  output  CNT_W  number of completed captures.

Behaviour:
- Clock and reset: one clock domain (CLK). Reset is asynchronous and active-high (RST).
- Reset values: state=IDLE, in_ready=1, res_valid=0, au_a/au_b/au_s/au_cin=0, res_data=0, res_zero=1, acc=0, op_count=0, settle counter=0.
- FSM states: IDLE, SETTLE, RESULT.
- IDLE:
  - in_ready=1.
  - On a posedge with in_valid=1, the request is accepted:
    - au_a <= (in_acc ? acc : in_a)
    - au_b <= in_b
    - {au_s,au_cin} <= in_mode
    - cnt <= SETTLE_CYCLES-1
    - in_ready <= 0
    - state <= SETTLE
- SETTLE:
  - in_ready=0; au_* outputs are held constant.
  - While cnt != 0: cnt <= cnt-1.
  - When cnt == 0:
    - res_data <= {au_cout,au_d}
    - res_zero <= (au_d==0)
    - acc <= au_d
    - op_count <= op_count+1
    - res_valid <= 1
    - state <= RESULT
- Latency: request accepted at edge k; capture and res_valid rise at edge k+SETTLE_CYCLES.
- RESULT:
  - res_valid=1; res_data, res_zero and acc are held stable.
  - in_ready=0; in_valid is ignored.
  - On a posedge with res_ready=1: res_valid <= 0, in_ready <= 1, state <= IDLE.
  - The earliest next acceptance is the edge after that.
- Backpressure: res_ready may stay low indefinitely; there is no timeout and no result loss.
- res_ready while in IDLE or SETTLE is ignored.
- au_* outputs keep their last values in RESULT and IDLE; they change only on acceptance.
- Arithmetic: the block does not recompute the result; res_data is exactly the sampled AU output.
- Expected AU function per in_mode:
  - 000: A+B
  - 001: A+B+1
  - 010: A+~B
  - 011: A+~B+1
  - 100: A
  - 101: A+1
  - 110: A+1111
  - 111: 5-bit 1,A
- op_count wraps from 2^CNT_W-1 to 0 silently.
- Reset asserted mid-SETTLE or mid-RESULT:
  - Immediate return to reset values regardless of CLK.
  - The in-flight operation is discarded and no capture occurs.
- Deassertion of RST is synchronous in effect: the first acceptance is possible at the first posedge after RST falls.

Test Plan:
- Basic add: after reset, in_a=5, in_b=3, in_mode=000, in_valid for 1 cycle, res_ready=1 → res_valid high for exactly 1 cycle, 2 edges after acceptance; res_data=01000, res_zero=0, acc=1000, op_count=1.
- Subtract via complement: in_a=5, in_b=3, in_mode=011 → res_data=10010, acc=0010. Then in_a=3, in_b=5, mode 011 → res_data=01110.
- Decrement wrap and zero flag:
  - A=0, mode 110 → res_data=01111, res_zero=0.
  - A=1, mode 110 → res_data=10000, res_zero=1.
- Accumulate: from reset, three requests with in_acc=1, mode 101 → acc 0001, 0010, 0011; op_count=3; in_a value ignored (drive 1111).
- Backpressure: hold res_ready=0 for 5 cycles in RESULT while in_valid=1 with new operands → res_valid, res_data and au_* stable; in_ready=0; no new acceptance. On release, one cycle later in_ready=1 and the pending in_valid is accepted.
- Reset and wrap:
  - Assert RST between edges during SETTLE → res_valid=0, au_*=0, acc=0, op_count=0 immediately; no capture afterwards.
  - Then run 256 ops with CNT_W=8 → op_count returns to 0.
